// File: rtl/datapath_ctrl_pkg.sv
// rtl/datapath_ctrl_pkg.sv - shared encodings and FSM state type for the datapath controller
package datapath_ctrl_pkg;

  localparam logic [6:0]  OP_R       = 7'b0110011;
  localparam logic [6:0]  OP_IMM     = 7'b0010011;
  localparam logic [6:0]  OP_LOAD    = 7'b0000011;
  localparam logic [6:0]  OP_STORE   = 7'b0100011;
  localparam logic [6:0]  OP_SYSTEM  = 7'b1110011;

  localparam logic [2:0]  FUNCT3_ADD = 3'b000;
  localparam logic [2:0]  FUNCT3_D   = 3'b011;

  localparam logic [6:0]  FUNCT7_ADD = 7'b0000000;
  localparam logic [6:0]  FUNCT7_SUB = 7'b0100000;

  localparam logic [31:0] EBREAK     = 32'h0010_0073;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

endpackage

// File: rtl/rv_decoder.sv
// rtl/rv_decoder.sv - combinational IR decode into datapath controls, immediate and illegal flag
module rv_decoder
  import datapath_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic [11:0] immediate,
  output logic        sub,
  output logic        rf_din_sel,
  output logic        ula_din2_sel,
  output logic        wr_rf,
  output logic        wr_mem,
  output logic        ebreak,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  // Defaults describe an idle datapath, which is also what an illegal word decodes to.
  always_comb begin
    immediate    = '0;
    sub          = 1'b0;
    rf_din_sel   = 1'b1;
    ula_din2_sel = 1'b0;
    wr_rf        = 1'b0;
    wr_mem       = 1'b0;
    ebreak       = 1'b0;
    illegal      = 1'b1;
    case (opcode)
      OP_R: begin
        if (funct3 == FUNCT3_ADD && (funct7 == FUNCT7_ADD || funct7 == FUNCT7_SUB)) begin
          illegal = 1'b0;
          sub     = (funct7 == FUNCT7_SUB);
          wr_rf   = 1'b1;
        end
      end
      OP_IMM: begin
        if (funct3 == FUNCT3_ADD) begin
          illegal      = 1'b0;
          ula_din2_sel = 1'b1;
          immediate    = ir[31:20];
          wr_rf        = 1'b1;
        end
      end
      OP_LOAD: begin
        if (funct3 == FUNCT3_D) begin
          illegal      = 1'b0;
          ula_din2_sel = 1'b1;
          immediate    = ir[31:20];
          rf_din_sel   = 1'b0;
          wr_rf        = 1'b1;
        end
      end
      OP_STORE: begin
        if (funct3 == FUNCT3_D) begin
          illegal      = 1'b0;
          ula_din2_sel = 1'b1;
          immediate    = {ir[31:25], ir[11:7]};
          wr_mem       = 1'b1;
        end
      end
      OP_SYSTEM: begin
        if (ir == EBREAK) begin
          illegal = 1'b0;
          ebreak  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - multi-cycle fetch/decode/exec sequencer driving the add/sub/load/store datapath
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            RUN,
  output logic            IM_REQ,
  output logic [PC_W-1:0] IM_ADDR,
  input  logic            IM_ACK,
  input  logic [31:0]     IM_DATA,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [11:0]     immediate,
  output logic            sub,
  output logic            WE_RF,
  output logic            WE_MEM,
  output logic            RF_din_sel,
  output logic            ULA_din2_sel,
  output logic            HALTED,
  output logic            ILLEGAL,
  output logic [31:0]     INSTRET
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     ir_q;
  logic [31:0]     instret_q;
  logic            illegal_q;

  logic dec_wr_rf, dec_wr_mem, dec_ebreak, dec_illegal;

  rv_decoder u_decoder (
    .ir           (ir_q),
    .immediate    (immediate),
    .sub          (sub),
    .rf_din_sel   (RF_din_sel),
    .ula_din2_sel (ULA_din2_sel),
    .wr_rf        (dec_wr_rf),
    .wr_mem       (dec_wr_mem),
    .ebreak       (dec_ebreak),
    .illegal      (dec_illegal)
  );

  assign rs1     = ir_q[19:15];
  assign rs2     = ir_q[24:20];
  assign rd      = ir_q[11:7];
  assign IM_ADDR = pc_q;
  assign INSTRET = instret_q;
  assign ILLEGAL = illegal_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Enables are decoded from the state register so an async reset clears them at once.
  always_comb begin
    state_d = state_q;
    IM_REQ  = 1'b0;
    WE_RF   = 1'b0;
    WE_MEM  = 1'b0;
    HALTED  = 1'b0;
    case (state_q)
      S_IDLE:   if (RUN) state_d = S_FETCH;
      S_FETCH: begin
        IM_REQ = 1'b1;
        if (IM_ACK) state_d = S_DECODE;
      end
      S_DECODE: state_d = (dec_ebreak || dec_illegal) ? S_HALT : S_EXEC;
      S_EXEC: begin
        WE_RF   = dec_wr_rf && (rd != 5'd0);
        WE_MEM  = dec_wr_mem;
        state_d = S_FETCH;
      end
      S_HALT:   HALTED = 1'b1;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (state_q == S_FETCH && IM_ACK) ir_q <= IM_DATA;
      if (state_q == S_DECODE && dec_illegal) illegal_q <= 1'b1;
      if (state_q == S_EXEC) begin
        pc_q      <= pc_q + PC_W'(4);
        instret_q <= instret_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - directed vector bench for datapath_ctrl
module tb_datapath_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N, RUN, IM_ACK;
  logic [31:0] IM_DATA;
  logic        IM_REQ;
  logic [31:0] IM_ADDR;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] immediate;
  logic        sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, HALTED, ILLEGAL;
  logic [31:0] INSTRET;

  always #5 CLK = ~CLK;

  datapath_ctrl #(.PC_W(32), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RST_N(RST_N), .RUN(RUN),
    .IM_REQ(IM_REQ), .IM_ADDR(IM_ADDR), .IM_ACK(IM_ACK), .IM_DATA(IM_DATA),
    .rs1(rs1), .rs2(rs2), .rd(rd), .immediate(immediate), .sub(sub),
    .WE_RF(WE_RF), .WE_MEM(WE_MEM), .RF_din_sel(RF_din_sel), .ULA_din2_sel(ULA_din2_sel),
    .HALTED(HALTED), .ILLEGAL(ILLEGAL), .INSTRET(INSTRET)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;

  typedef struct {
    logic [31:0] word;
    int          delay;
    logic [4:0]  rs1, rs2, rd;
    logic        chk_imm;
    logic [11:0] imm;
    logic        sub;
    logic        din2;
    logic        chk_rf;
    logic        rfsel;
    int          n_rf;
    int          n_mem;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Leaves the bench at the negedge of the DECODE cycle.
  task automatic fetch(input logic [31:0] word, input int delay);
    bit ok = 0;
    int n  = 0;
    IM_ACK = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (IM_REQ) begin ok = 1; break; end
      @(negedge CLK);
    end
    if (!ok) timeout("wait_req");
    chk("im_addr", IM_ADDR, exp_pc);
    while (n < delay) begin
      @(negedge CLK);
      n++;
    end
    chk("req_held", 32'(IM_REQ), 32'd1);
    chk("req_addr_held", IM_ADDR, exp_pc);
    IM_ACK  = 1'b1;
    IM_DATA = word;
    @(negedge CLK);
    IM_ACK  = 1'b0;
    IM_DATA = $urandom;
  endtask

  task automatic run_vec(input vec_t v);
    int nrf = 0;
    int nmem = 0;
    fetch(v.word, v.delay);
    for (int ph = 0; ph < 2; ph++) begin
      chk("rs1", 32'(rs1), 32'(v.rs1));
      chk("rs2", 32'(rs2), 32'(v.rs2));
      chk("rd", 32'(rd), 32'(v.rd));
      if (v.chk_imm) chk("immediate", 32'(immediate), 32'(v.imm));
      chk("sub", 32'(sub), 32'(v.sub));
      chk("din2_sel", 32'(ULA_din2_sel), 32'(v.din2));
      if (v.chk_rf) chk("rf_din_sel", 32'(RF_din_sel), 32'(v.rfsel));
      if (ph == 0) begin
        chk("decode_we_rf", 32'(WE_RF), 32'd0);
        chk("decode_we_mem", 32'(WE_MEM), 32'd0);
      end
      nrf  += int'(WE_RF);
      nmem += int'(WE_MEM);
      @(negedge CLK);
    end
    exp_pc  = exp_pc + 32'd4;
    exp_ret = exp_ret + 32'd1;
    chk("we_rf_pulses", 32'(nrf), 32'(v.n_rf));
    chk("we_mem_pulses", 32'(nmem), 32'(v.n_mem));
    chk("refetch_req", 32'(IM_REQ), 32'd1);
    chk("next_pc", IM_ADDR, exp_pc);
    chk("instret", INSTRET, exp_ret);
  endtask

  task automatic check_sticky(input logic exp_ill);
    for (int i = 0; i < 10; i++) begin
      RUN     = 1'($urandom);
      IM_ACK  = 1'(i & 1);
      IM_DATA = 32'h0050_0093;
      @(negedge CLK);
      chk("halt_sticky", 32'(HALTED), 32'd1);
      chk("ill_sticky", 32'(ILLEGAL), 32'(exp_ill));
      chk("halt_no_req", 32'(IM_REQ), 32'd0);
      chk("halt_no_we", 32'(WE_RF | WE_MEM), 32'd0);
      chk("halt_pc", IM_ADDR, exp_pc);
      chk("halt_instret", INSTRET, exp_ret);
    end
    IM_ACK = 1'b0;
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    RUN   = 1'b0;
    IM_ACK = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    exp_pc  = 32'h0;
    exp_ret = 32'h0;
  endtask

  initial begin
    //          word          dly rs1 rs2 rd  ci imm     sub d2 cr rf nrf nmem
    vecs[0] = '{32'h0050_0093, 0, 5'd0, 5'd5,  5'd1,  1, 12'h005, 0, 1, 1, 1, 1, 0};
    vecs[1] = '{32'h4020_81B3, 3, 5'd1, 5'd2,  5'd3,  0, 12'h000, 1, 0, 1, 1, 1, 0};
    vecs[2] = '{32'hFE20_BC23, 0, 5'd1, 5'd2,  5'd24, 1, 12'hFF8, 0, 1, 0, 0, 0, 1};
    vecs[3] = '{32'hFF80_B203, 2, 5'd1, 5'd24, 5'd4,  1, 12'hFF8, 0, 1, 1, 0, 1, 0};
    vecs[4] = '{32'h0020_82B3, 1, 5'd1, 5'd2,  5'd5,  0, 12'h000, 0, 0, 1, 1, 1, 0};
    vecs[5] = '{32'h0010_0013, 0, 5'd0, 5'd1,  5'd0,  1, 12'h001, 0, 1, 1, 1, 0, 0};

    RST_N = 1'b0; RUN = 1'b0; IM_ACK = 1'b0; IM_DATA = '0;
    exp_pc = '0; exp_ret = '0;
    @(negedge CLK);
    chk("rst_req", 32'(IM_REQ), 32'd0);
    chk("rst_addr", IM_ADDR, 32'h0);
    chk("rst_sel", {rs1, rs2, rd, immediate}, 32'h0);
    chk("rst_ctl", {27'd0, sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel}, 32'h2);
    chk("rst_status", {30'd0, HALTED, ILLEGAL}, 32'h0);
    chk("rst_instret", INSTRET, 32'h0);
    RST_N = 1'b1;

    // Idle ignores stray acks while RUN is low.
    IM_ACK = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("idle_no_req", 32'(IM_REQ), 32'd0);
    end
    IM_ACK = 1'b0;
    RUN = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Illegal word halts with ILLEGAL and no writes.
    fetch(32'hFFFF_FFFF, 0);
    chk("ill_decode_we", 32'(WE_RF | WE_MEM), 32'd0);
    @(negedge CLK);
    chk("ill_halted", 32'(HALTED), 32'd1);
    chk("ill_flag", 32'(ILLEGAL), 32'd1);
    check_sticky(1'b1);

    // ebreak halts cleanly without retiring.
    apply_reset();
    RUN = 1'b1;
    fetch(32'h0010_0073, 1);
    chk("ebreak_decode_we", 32'(WE_RF | WE_MEM), 32'd0);
    @(negedge CLK);
    chk("ebreak_halted", 32'(HALTED), 32'd1);
    chk("ebreak_not_ill", 32'(ILLEGAL), 32'd0);
    chk("ebreak_instret", INSTRET, 32'd0);
    check_sticky(1'b0);

    // Reset in the middle of EXEC of the second instruction.
    apply_reset();
    RUN = 1'b1;
    run_vec(vecs[0]);
    fetch(32'h0070_0113, 0);
    @(negedge CLK);
    chk("exec_we_before_rst", 32'(WE_RF), 32'd1);
    chk("exec_pc_before_rst", IM_ADDR, 32'd4);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_we", 32'(WE_RF | WE_MEM), 32'd0);
    chk("mid_rst_pc", IM_ADDR, 32'h0);
    chk("mid_rst_instret", INSTRET, 32'h0);
    chk("mid_rst_sel", {rs1, rs2, rd, immediate}, 32'h0);
    chk("mid_rst_ctl", {27'd0, sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel}, 32'h2);
    chk("mid_rst_req", 32'(IM_REQ), 32'd0);
    @(negedge CLK);
    RUN = 1'b0;
    IM_ACK = 1'b1;
    RST_N = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("post_rst_idle", 32'(IM_REQ), 32'd0);
      chk("post_rst_pc", IM_ADDR, 32'h0);
    end
    IM_ACK = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Multi-cycle control unit that sequences the add/sub/load/store datapath. It fetches 32-bit RV64 instructions from an instruction memory over a req/ack handshake and decodes `add`, `sub`, `addi`, `ld` and `sd`. It drives the datapath's register selectors, immediate, ALU and mux selects, and write enables, one instruction at a time. It sits beside the datapath inside the core top level, and is the only driver of the datapath control inputs.

## Interface
Parameters:
- `PC_W`, 32: program counter / instruction address width.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `CLK` in 1: single clock, all state updates on rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `RUN` in 1: leave IDLE and start fetching.
- `IM_REQ` out 1: instruction fetch request.
- `IM_ADDR` out PC_W: fetch address (= PC).
- `IM_ACK` in 1: fetch data valid this cycle.
- `IM_DATA` in 32: instruction word.
- `rs1`, `rs2`, `rd` out 5 each: datapath register selectors.
- `immediate` out 12: I- or S-format immediate.
- `sub` out 1: ALU subtract.
- `WE_RF` out 1: register file write enable.
- `WE_MEM` out 1: data memory write enable.
- `RF_din_sel` out 1: 1 = ALU result to register file, 0 = data memory.
- `ULA_din2_sel` out 1: 1 = immediate to ALU operand 2, 0 = rs2 data.
- `HALTED` out 1: controller stopped.
- `ILLEGAL` out 1: stop was caused by an unsupported instruction.
- `INSTRET` out 32: retired-instruction counter.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- **IDLE:** all enables low. When `RUN`=1, go to FETCH.
- **FETCH:**
  - `IM_REQ`=1 and `IM_ADDR`=PC, held until the edge where `IM_ACK`=1.
  - On that edge, IR <= `IM_DATA` and go to DECODE. `RUN` is ignored outside IDLE.
- **DECODE (1 cycle):**
  - Outputs are decoded from IR; `WE_RF`=`WE_MEM`=0.
  - Go to EXEC, or to HALT if IR is `ebreak` (0x00100073) or illegal.
- **EXEC (1 cycle):**
  - Same decoded outputs as DECODE, with the write enable for the instruction class asserted.
  - On the exit edge: PC <= PC+4 (mod 2^PC_W), `INSTRET` <= `INSTRET`+1 (wraps), go to FETCH.
- **Decode table** (opcode/funct3/funct7):
  - `add` 0110011/000/0000000: `ULA_din2_sel`=0, `sub`=0, `RF_din_sel`=1, `WE_RF`.
  - `sub` 0110011/000/0100000: as `add` but `sub`=1.
  - `addi` 0010011/000: `ULA_din2_sel`=1, `immediate`=IR[31:20], `RF_din_sel`=1, `WE_RF`.
  - `ld` 0000011/011: `ULA_din2_sel`=1, `immediate`=IR[31:20], `RF_din_sel`=0, `WE_RF`.
  - `sd` 0100011/011: `ULA_din2_sel`=1, `immediate`={IR[31:25],IR[11:7]}, `WE_MEM`.
  - Any other encoding is illegal: HALT with `ILLEGAL`=1.
- `rs1`=IR[19:15], `rs2`=IR[24:20] and `rd`=IR[11:7] are always driven from IR.
- `WE_RF` is suppressed when `rd`=0.
- **HALT:** sticky until `RST_N` low. `HALTED`=1; PC and `INSTRET` are frozen. `ebreak` does not increment `INSTRET`.

## Timing
- Reset values (asynchronous, immediate on `RST_N` low):
  - state = IDLE, PC = `RESET_PC`, IR = 0.
  - `rs1`/`rs2`/`rd`/`immediate` = 0.
  - `sub`/`WE_RF`/`WE_MEM`/`IM_REQ`/`ULA_din2_sel` = 0, `RF_din_sel`=1.
  - `HALTED`/`ILLEGAL` = 0, `INSTRET` = 0.
- Instruction latency: 3 cycles when `IM_ACK` arrives in the first FETCH cycle, plus 1 cycle per wait cycle.
- Operand and select outputs are registered from IR. They are stable from DECODE through the end of EXEC, so datapath combinational paths have a full settle cycle before the write edge.
- Write enables are high for exactly one cycle per instruction, only in EXEC.
- `IM_ACK` while `IM_REQ`=0 is ignored.
- `RST_N` asserted mid-EXEC drops the write enables immediately. No partial PC or `INSTRET` update occurs.

## Structure
- Package `datapath_ctrl_pkg`: opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_SYSTEM), FUNCT3_ADD/FUNCT3_D, FUNCT7_ADD/FUNCT7_SUB, EBREAK word, state enum.
- Sub-module `rv_decoder`: purely combinational IR -> control/immediate/illegal. The top level holds the FSM, PC, IR and `INSTRET`.

## Test plan
- Reset then `RUN`=1, memory ACKs immediately with `addi x1,x0,5` (0x00500093) -> `IM_ADDR`=0, `WE_RF` high one cycle in EXEC with `rd`=1, `immediate`=5, `ULA_din2_sel`=1, `RF_din_sel`=1; next `IM_ADDR`=4; `INSTRET`=1.
- `sub x3,x1,x2` (0x402081B3) with `IM_ACK` delayed 3 cycles -> `IM_REQ` held 4 cycles, then `sub`=1, `ULA_din2_sel`=0, one `WE_RF` pulse; total 6 cycles.
- `sd x2,-8(x1)` (0xFE20BC23) -> `immediate`=0xFF8, `WE_MEM` one cycle, `WE_RF` never high. `ld x4,-8(x1)` (0xFF80B203) -> `RF_din_sel`=0, `WE_RF` one cycle.
- `addi x0,x0,1` -> no `WE_RF` pulse; PC advances; `INSTRET` increments.
- Word 0xFFFFFFFF -> HALT, `HALTED`=1, `ILLEGAL`=1, no writes. `ebreak` -> `HALTED`=1, `ILLEGAL`=0, `INSTRET` unchanged. Both states stay sticky across 10 cycles of `RUN`/`IM_ACK` activity.
- Assert `RST_N` low mid-EXEC -> all outputs at reset values in the same cycle, PC = `RESET_PC`, state IDLE.
